// File: rtl/dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl_pkg
// Description : Shared types and constants for the instruction queue/dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_ctrl_pkg;

  localparam int IQ_DEPTH_DEF = 16;
  localparam int IQ_PTR_W_DEF = 4;
  localparam int IQ_ENTRY_W   = 65;

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } openum_e;

  // Loads occupy one contiguous range of the operation encoding.
  localparam logic [5:0] OPENUM_LB  = OP_LB;
  localparam logic [5:0] OPENUM_LHU = OP_LHU;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_jump;
  } iq_entry_t;

  typedef struct packed {
    logic [5:0]  openum;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        pred_jump;
    logic        is_jump;
    logic        is_store;
    logic        is_branch;
  } dis_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op >= OPENUM_LB) && (op <= OPENUM_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl_decoder
// Description : Combinational RV32I decoder; unknown encodings decode to NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ctrl_decoder
  import dispatch_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output logic [5:0]  openum,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        is_jump,
  output logic        is_store,
  output logic        is_branch
);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  openum_e     op;
  fmt_e        fmt;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    op  = OP_NOP;
    fmt = FMT_R;
    case (opcode)
      7'b0110111: begin op = OP_LUI;   fmt = FMT_U; end
      7'b0010111: begin op = OP_AUIPC; fmt = FMT_U; end
      7'b1101111: begin op = OP_JAL;   fmt = FMT_J; end
      7'b1100111: begin
        fmt = FMT_I;
        if (funct3 == 3'd0) op = OP_JALR;
      end
      7'b1100011: begin
        fmt = FMT_B;
        case (funct3)
          3'd0: op = OP_BEQ;
          3'd1: op = OP_BNE;
          3'd4: op = OP_BLT;
          3'd5: op = OP_BGE;
          3'd6: op = OP_BLTU;
          3'd7: op = OP_BGEU;
          default: ;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I;
        case (funct3)
          3'd0: op = OP_LB;
          3'd1: op = OP_LH;
          3'd2: op = OP_LW;
          3'd4: op = OP_LBU;
          3'd5: op = OP_LHU;
          default: ;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S;
        case (funct3)
          3'd0: op = OP_SB;
          3'd1: op = OP_SH;
          3'd2: op = OP_SW;
          default: ;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I;
        case (funct3)
          3'd0: op = OP_ADDI;
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd6: op = OP_ORI;
          3'd7: op = OP_ANDI;
          3'd1: if (funct7 == 7'h00) op = OP_SLLI;
          3'd5: begin
            if (funct7 == 7'h00)      op = OP_SRLI;
            else if (funct7 == 7'h20) op = OP_SRAI;
          end
          default: ;
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R;
        case ({funct7, funct3})
          {7'h00, 3'd0}: op = OP_ADD;
          {7'h20, 3'd0}: op = OP_SUB;
          {7'h00, 3'd1}: op = OP_SLL;
          {7'h00, 3'd2}: op = OP_SLT;
          {7'h00, 3'd3}: op = OP_SLTU;
          {7'h00, 3'd4}: op = OP_XOR;
          {7'h00, 3'd5}: op = OP_SRL;
          {7'h20, 3'd5}: op = OP_SRA;
          {7'h00, 3'd6}: op = OP_OR;
          {7'h00, 3'd7}: op = OP_AND;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Register fields a format does not use are forced to zero (x0).
  always_comb begin
    rd  = '0;
    rs1 = '0;
    rs2 = '0;
    imm = '0;
    if (op != OP_NOP) begin
      case (fmt)
        FMT_R: begin rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20]; end
        FMT_I: begin
          rd  = inst[11:7];
          rs1 = inst[19:15];
          imm = (op inside {OP_SLLI, OP_SRLI, OP_SRAI}) ? {27'd0, inst[24:20]} : imm_i;
        end
        FMT_S: begin rs1 = inst[19:15]; rs2 = inst[24:20]; imm = imm_s; end
        FMT_B: begin rs1 = inst[19:15]; rs2 = inst[24:20]; imm = imm_b; end
        FMT_U: begin rd = inst[11:7]; imm = imm_u; end
        FMT_J: begin rd = inst[11:7]; imm = imm_j; end
        default: ;
      endcase
    end
  end

  assign openum    = op;
  assign is_jump   = (op == OP_JAL) || (op == OP_JALR);
  assign is_store  = op inside {OP_SB, OP_SH, OP_SW};
  assign is_branch = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};

endmodule
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl
// Description : Circular instruction queue with single-issue dispatch to ROB/RS/LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF,
  parameter int IQ_PTR_W = IQ_PTR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] inst_pc,
  input  logic        inst_pred_jump,
  output logic        iq_full,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  output logic        rob_en,
  output logic        rs_en,
  output logic        lsb_en,
  output logic [5:0]  dis_openum,
  output logic [4:0]  dis_rd,
  output logic [4:0]  dis_rs1,
  output logic [4:0]  dis_rs2,
  output logic [31:0] dis_imm,
  output logic [31:0] dis_pc,
  output logic        dis_pred_jump,
  output logic        dis_is_jump,
  output logic        dis_is_store,
  output logic        dis_is_branch
);

  localparam int CNT_W = IQ_PTR_W + 1;

  iq_entry_t           iq_q [IQ_DEPTH];
  iq_entry_t           head_entry;
  iq_entry_t           new_entry;
  logic [IQ_PTR_W-1:0] head_q, head_d;
  logic [IQ_PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rob_en_q, rob_en_d;
  logic                rs_en_q, rs_en_d;
  logic                lsb_en_q, lsb_en_d;
  dis_t                dis_q, dis_d;

  logic [5:0]  dec_openum;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_is_jump, dec_is_store, dec_is_branch;
  logic        mem_op, enq, fire;

  assign head_entry = iq_q[head_q];
  assign new_entry  = '{inst: inst, pc: inst_pc, pred_jump: inst_pred_jump};

  dispatch_ctrl_decoder u_decoder (
    .inst      (head_entry.inst),
    .openum    (dec_openum),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .imm       (dec_imm),
    .is_jump   (dec_is_jump),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch)
  );

  assign iq_full = (count_q == CNT_W'(IQ_DEPTH));
  assign mem_op  = is_load_op(dec_openum) || dec_is_store;
  assign enq     = inst_valid && !iq_full && !rollback;
  assign fire    = (count_q != '0) && !rollback && !rob_full && (mem_op ? !lsb_full : !rs_full);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rob_en_d = 1'b0;
    rs_en_d  = 1'b0;
    lsb_en_d = 1'b0;
    dis_d    = dis_q;
    if (rdy) begin
      if (rollback) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (enq) tail_d = tail_q + IQ_PTR_W'(1);
        if (fire) begin
          head_d          = head_q + IQ_PTR_W'(1);
          dis_d.openum    = dec_openum;
          dis_d.rd        = dec_rd;
          dis_d.rs1       = dec_rs1;
          dis_d.rs2       = dec_rs2;
          dis_d.imm       = dec_imm;
          dis_d.pc        = head_entry.pc;
          dis_d.pred_jump = head_entry.pred_jump;
          dis_d.is_jump   = dec_is_jump;
          dis_d.is_store  = dec_is_store;
          dis_d.is_branch = dec_is_branch;
          // A NOP still consumes the slot but raises no strobes.
          if (dec_openum != OP_NOP) begin
            rob_en_d = 1'b1;
            lsb_en_d = mem_op;
            rs_en_d  = !mem_op;
          end
        end
        if (enq && !fire)      count_d = count_q + CNT_W'(1);
        else if (!enq && fire) count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rob_en_q <= 1'b0;
      rs_en_q  <= 1'b0;
      lsb_en_q <= 1'b0;
      dis_q    <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rob_en_q <= rob_en_d;
      rs_en_q  <= rs_en_d;
      lsb_en_q <= lsb_en_d;
      dis_q    <= dis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && enq) iq_q[tail_q] <= new_entry;
  end

  assign rob_en        = rob_en_q;
  assign rs_en         = rs_en_q;
  assign lsb_en        = lsb_en_q;
  assign dis_openum    = dis_q.openum;
  assign dis_rd        = dis_q.rd;
  assign dis_rs1       = dis_q.rs1;
  assign dis_rs2       = dis_q.rs2;
  assign dis_imm       = dis_q.imm;
  assign dis_pc        = dis_q.pc;
  assign dis_pred_jump = dis_q.pred_jump;
  assign dis_is_jump   = dis_q.is_jump;
  assign dis_is_store  = dis_q.is_store;
  assign dis_is_branch = dis_q.is_branch;

endmodule
`default_nettype wire

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Instruction queue and dispatch scheduler between the fetcher and the back end (ROB, reservation station RS, load/store buffer LSB).
- Buffers fetched instructions in a circular FIFO and decodes the head entry through the existing combinational decoder.
- Issues at most one instruction per cycle to ROB plus RS or LSB when every target has space.
- Flushes completely on rollback.

Parameters:
- IQ_DEPTH, 16, queue entries; power of two, at least 4.
- IQ_PTR_W, 4, log2(IQ_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes all state
- rollback  in  1  misprediction flush
- inst_valid  in  1  fetcher offers an instruction
- inst  in  32  instruction word
- inst_pc  in  32  PC of inst
- inst_pred_jump  in  1  fetcher's predicted-taken flag
- iq_full  out  1  queue cannot accept this cycle
- rob_full  in  1  ROB has no free slot
- rs_full  in  1  RS has no free slot
- lsb_full  in  1  LSB has no free slot
- rob_en  out  1  ROB allocate strobe
- rs_en  out  1  RS issue strobe
- lsb_en  out  1  LSB issue strobe
- dis_openum  out  6  decoded operation
- dis_rd  out  5  destination register
- dis_rs1  out  5  source register 1
- dis_rs2  out  5  source register 2
- dis_imm  out  32  immediate
- dis_pc  out  32  instruction PC
- dis_pred_jump  out  1  prediction flag
- dis_is_jump  out  1  decoder jump flag
- dis_is_store  out  1  decoder store flag
- dis_is_branch  out  1  decoder branch flag

Behaviour:
- Reset: head = tail = count = 0; all *_en = 0; all dis_* = 0; iq_full = 0.
- Reset overrides rollback and rdy.
- rdy = 0: no register changes; *_en are cleared so a strobe lasts exactly one cycle.
- iq_full is combinational: count == IQ_DEPTH.
- Enqueue: inst_valid && !iq_full && !rollback. Writes {inst, inst_pc, inst_pred_jump} at tail; tail wraps modulo IQ_DEPTH.
- Head decode: fully combinational from the head entry.
  - is_load is true when openum is one of LB, LH, LW, LBU, LHU.
  - mem_op = is_load || is_store.
- Dispatch fires when: count != 0 && !rollback && !rob_full && (mem_op ? !lsb_full : !rs_full).
- On fire: head advances (with wrap); next cycle rob_en = 1 and exactly one of lsb_en (mem_op) or rs_en (all other ops) is 1.
  - All dis_* are registered from the head decode in the same edge.
  - Issue latency is 1 cycle; the queue sustains 1 instruction per cycle.
- NOP openum (unknown opcode): head is dequeued and discarded; no strobes next cycle. The slot still consumes the dispatch cycle.
- No fire: all *_en = 0 next cycle; dis_* hold their previous values.
- Simultaneous enqueue and dispatch: count unchanged; pointers both advance. At count == IQ_DEPTH the enqueue is refused and only the dequeue happens.
- Empty queue: no dispatch; an instruction enqueued in cycle N can be issued by the edge ending cycle N+1, at the earliest. There is no bypass from inst to the dispatch outputs.
- Rollback: at the next edge head = tail = count = 0 and all *_en = 0. A same-cycle inst_valid is dropped and a same-cycle dispatch is suppressed.
- Fullness checks use the registered *_full values of the current cycle. The downstream unit must deassert *_full early enough to absorb the strobe issued on that cycle.
- count width is IQ_PTR_W+1 bits. Wrap is a natural pointer overflow.

Decomposition:
- Shared defines header (existing) gains:
  - IQ_DEPTH and IQ_PTR_W defaults.
  - OPENUM_LB..OPENUM_LHU range bounds for the is_load test.
  - IQ_ENTRY_TYPE width (65 bits).
- Sub-module: instantiate the existing combinational instruction decoder on the head instruction. No other sub-module; the FIFO stays inline.

Test Plan:
- Reset, then enqueue 0x00500093 (addi x1,x0,5) at pc 0x0, all fulls low.
  - Next cycle: count = 1.
  - Following cycle: rob_en = rs_en = 1, lsb_en = 0, dis_rd = 1, dis_imm = 5, dis_pc = 0.
- Enqueue 0x0040A103 (lw x2,4(x1)) then 0x0020A423 (sw x2,8(x1)).
  - lsb_en pulses on two consecutive cycles.
  - Second issue: dis_is_store = 1, dis_rd = 0, dis_imm = 8.
- Hold rs_full = 1 and enqueue addi: no strobes, count stays 1. Drop rs_full: issue exactly once.
- Enqueue 16 instructions with rob_full = 1: iq_full = 1, a 17th inst_valid is ignored. Release rob_full: 16 issues on consecutive cycles with pointer wrap, iq_full falls after the first issue.
- Assert rollback with count = 5 and inst_valid = 1: next cycle count = 0, all *_en = 0, iq_full = 0, nothing issues later.
- Enqueue 0x00000463 (beq x0,x0,+8) with inst_pred_jump = 1 and rdy = 0 for 3 cycles: nothing moves. Raise rdy: rs_en = 1, dis_is_branch = 1, dis_imm = 8, dis_pred_jump = 1.
